// File: rtl/calc1_resp_checker_pkg.sv
// Shared encodings for the calc1 response checker: command/response codes,
// fail causes and the checker FSM state type.
package calc1_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_LSH = 4'd5;
    localparam logic [3:0] CMD_RSH = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;
    localparam logic [1:0] RESP_INT  = 2'd3;

    // Lower value wins when several causes coincide in one cycle.
    localparam logic [2:0] FAIL_NONE     = 3'd0;
    localparam logic [2:0] FAIL_DATA     = 3'd1;
    localparam logic [2:0] FAIL_RESP     = 3'd2;
    localparam logic [2:0] FAIL_TIMEOUT  = 3'd3;
    localparam logic [2:0] FAIL_SPURIOUS = 3'd4;
    localparam logic [2:0] FAIL_OVERLAP  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OP2    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

endpackage

// File: rtl/calc1_resp_checker_if.sv
// Observed calc1 port signals. The port side drives them (master); the
// checker only watches them (slave). Bit 0 is the MSB on every bus.
interface calc1_resp_checker_if;
    logic [0:3]  req_cmd_in;
    logic [0:31] req_data_in;
    logic [0:1]  out_resp_in;
    logic [0:31] out_data_in;

    modport master (output req_cmd_in, output req_data_in,
                    output out_resp_in, output out_data_in);
    modport slave  (input  req_cmd_in, input  req_data_in,
                    input  out_resp_in, input  out_data_in);
endinterface

// File: rtl/calc1_resp_checker_ref.sv
// Combinational reference of the calc1 arithmetic: what a correct port
// should answer for a captured command and operand pair.
module calc1_ref_model
    import calc1_pkg::*;
(
    input  logic [0:3]  cmd_i,
    input  logic [0:31] op1_i,
    input  logic [0:31] op2_i,
    output logic [0:1]  exp_resp_o,
    output logic [0:31] exp_data_o
);
    logic [32:0] sum_ext;
    logic [4:0]  shamt;

    always_comb begin
        sum_ext    = {1'b0, op1_i} + {1'b0, op2_i};
        shamt      = op2_i[27:31];
        exp_resp_o = RESP_ERR;
        exp_data_o = '0;
        case (cmd_i)
            CMD_NOP: exp_resp_o = RESP_NONE;
            CMD_ADD: begin
                exp_data_o = sum_ext[31:0];
                exp_resp_o = sum_ext[32] ? RESP_ERR : RESP_OK;
            end
            CMD_SUB: begin
                exp_data_o = op1_i - op2_i;
                exp_resp_o = (op2_i > op1_i) ? RESP_ERR : RESP_OK;
            end
            CMD_LSH: begin
                exp_data_o = op1_i << shamt;
                exp_resp_o = RESP_OK;
            end
            CMD_RSH: begin
                exp_data_o = op1_i >> shamt;
                exp_resp_o = RESP_OK;
            end
            default: exp_resp_o = RESP_ERR;
        endcase
    end
endmodule

// File: rtl/calc1_resp_checker.sv
// Per-port calc1 response checker: tracks one outstanding command, compares
// the port's answer to the reference model and pulses pass/fail events.
module calc1_resp_checker
    import calc1_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32,
    parameter int PORT_ID        = 1
) (
    input  logic                 c_clk,
    input  logic                 reset_n,
    calc1_resp_checker_if.slave  mon,
    output logic                 chk_pass,
    output logic                 chk_fail,
    output logic [2:0]           fail_code,
    output logic [15:0]          pass_count,
    output logic [15:0]          fail_count,
    output logic                 busy,
    output logic [2:0]           event_port_o,
    output state_e               dbg_state_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_e      state_q, state_d;
    logic [0:3]  cmd_q, cmd_d;
    logic [0:31] op1_q, op1_d;
    logic [0:31] op2_q, op2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        pass_q, pass_d;
    logic [2:0]  fcode_q, fcode_d;
    logic [15:0] pass_cnt_q, fail_cnt_q;
    logic [0:1]  exp_resp;
    logic [0:31] exp_data;
    logic        cmd_seen, resp_seen;

    calc1_ref_model u_ref (
        .cmd_i      (cmd_q),
        .op1_i      (op1_q),
        .op2_i      (op2_q),
        .exp_resp_o (exp_resp),
        .exp_data_o (exp_data)
    );

    assign cmd_seen  = (mon.req_cmd_in != '0);
    assign resp_seen = (mon.out_resp_in != '0);

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        cnt_d   = cnt_q;
        pass_d  = 1'b0;
        fcode_d = FAIL_NONE;
        case (state_q)
            ST_IDLE, ST_REPORT: begin
                if (state_q == ST_IDLE && resp_seen) fcode_d = FAIL_SPURIOUS;
                if (cmd_seen) begin
                    cmd_d   = mon.req_cmd_in;
                    op1_d   = mon.req_data_in;
                    state_d = ST_OP2;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OP2: begin
                if (resp_seen) fcode_d = FAIL_SPURIOUS;
                op2_d   = mon.req_data_in;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A command here is an overlap: flagged, but never captured.
                if (resp_seen) begin
                    state_d = ST_REPORT;
                    if (mon.out_resp_in != exp_resp)
                        fcode_d = FAIL_RESP;
                    else if (exp_resp == RESP_OK && mon.out_data_in != exp_data)
                        fcode_d = FAIL_DATA;
                    else
                        pass_d = 1'b1;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    fcode_d = FAIL_TIMEOUT;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (cmd_seen && fcode_d == FAIL_NONE) fcode_d = FAIL_OVERLAP;
            end
            default: state_d = ST_IDLE;
        endcase
        if (fcode_d != FAIL_NONE) pass_d = 1'b0;
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            cnt_q      <= '0;
            pass_q     <= 1'b0;
            fcode_q    <= FAIL_NONE;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            fcode_q <= fcode_d;
            if (pass_d && pass_cnt_q != 16'hFFFF)
                pass_cnt_q <= pass_cnt_q + 16'd1;
            if (fcode_d != FAIL_NONE && fail_cnt_q != 16'hFFFF)
                fail_cnt_q <= fail_cnt_q + 16'd1;
        end
    end

    assign chk_pass     = pass_q;
    assign chk_fail     = (fcode_q != FAIL_NONE);
    assign fail_code    = fcode_q;
    assign pass_count   = pass_cnt_q;
    assign fail_count   = fail_cnt_q;
    assign busy         = (state_q == ST_OP2) || (state_q == ST_WAIT);
    assign event_port_o = (pass_q || chk_fail) ? 3'(PORT_ID) : 3'd0;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_calc1_resp_checker.sv
// Directed scenarios for calc1_resp_checker with hand-computed expectations.
module tb_calc1_resp_checker;
    import calc1_pkg::*;

    logic        c_clk;
    logic        reset_n;
    logic        chk_pass, chk_fail, busy;
    logic [2:0]  fail_code, event_port;
    logic [15:0] pass_count, fail_count;
    state_e      dbg_state;
    int          checks;
    int          failures;
    int          exp_pass;
    int          exp_fail;

    calc1_resp_checker_if bus ();

    calc1_resp_checker #(.TIMEOUT_CYCLES(32), .PORT_ID(1)) dut (
        .c_clk        (c_clk),
        .reset_n      (reset_n),
        .mon          (bus.slave),
        .chk_pass     (chk_pass),
        .chk_fail     (chk_fail),
        .fail_code    (fail_code),
        .pass_count   (pass_count),
        .fail_count   (fail_count),
        .busy         (busy),
        .event_port_o (event_port),
        .dbg_state_o  (dbg_state)
    );

    // clock / reset
    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    // driver tasks
    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.req_cmd_in  = '0;
        bus.req_data_in = '0;
        bus.out_resp_in = '0;
        bus.out_data_in = '0;
    endtask

    // Leaves the checker in WAIT with its cycle counter freshly cleared.
    task automatic issue(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2);
        bus.req_cmd_in  = cmd;
        bus.req_data_in = op1;
        tick();
        bus.req_cmd_in  = '0;
        bus.req_data_in = op2;
        tick();
        bus.req_data_in = '0;
    endtask

    task automatic respond(input logic [1:0] resp, input logic [31:0] data);
        bus.out_resp_in = resp;
        bus.out_data_in = data;
        tick();
        bus.out_resp_in = '0;
        bus.out_data_in = '0;
    endtask

    // scenarios
    task automatic test_reset();
        reset_n = 1'b0;
        drive_idle();
        tick();
        tick();
        checks++;
        if (chk_pass !== 1'b0 || chk_fail !== 1'b0 || fail_code !== 3'd0) begin
            failures++;
            $display("FAIL reset_pulses got pass=%b fail=%b code=%0d exp 0/0/0", chk_pass, chk_fail, fail_code);
        end
        checks++;
        if (pass_count !== 16'd0 || fail_count !== 16'd0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state got pc=%0d fc=%0d busy=%b st=%0d exp 0/0/0/0", pass_count, fail_count, busy, dbg_state);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_add_pass();
        issue(CMD_ADD, 32'hFFFF0000, 32'h0000FFFF);
        checks++;
        if (busy !== 1'b1 || dbg_state !== ST_WAIT) begin
            failures++;
            $display("FAIL add_busy got busy=%b st=%0d exp 1/%0d", busy, dbg_state, ST_WAIT);
        end
        tick();
        tick();
        respond(RESP_OK, 32'hFFFFFFFF);
        exp_pass++;
        checks++;
        if (chk_pass !== 1'b1 || chk_fail !== 1'b0 || pass_count !== 16'(exp_pass) || event_port !== 3'd1) begin
            failures++;
            $display("FAIL add_pass got pass=%b fail=%b pc=%0d port=%0d exp 1/0/%0d/1", chk_pass, chk_fail, pass_count, event_port, exp_pass);
        end
        tick();
        checks++;
        if (chk_pass !== 1'b0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL add_after got pass=%b busy=%b st=%0d exp 0/0/0", chk_pass, busy, dbg_state);
        end
    endtask

    task automatic test_add_overflow();
        issue(CMD_ADD, 32'hFFFFFFFF, 32'h00000001);
        respond(RESP_OK, 32'h00000000);
        exp_fail++;
        checks++;
        if (chk_fail !== 1'b1 || chk_pass !== 1'b0 || fail_code !== FAIL_RESP || fail_count !== 16'(exp_fail)) begin
            failures++;
            $display("FAIL add_ovf got fail=%b pass=%b code=%0d fc=%0d exp 1/0/2/%0d", chk_fail, chk_pass, fail_code, fail_count, exp_fail);
        end
        tick();
    endtask

    task automatic test_shift();
        issue(CMD_LSH, 32'h00000001, 32'h00000021);
        respond(RESP_OK, 32'h00000002);
        exp_pass++;
        checks++;
        if (chk_pass !== 1'b1 || chk_fail !== 1'b0) begin
            failures++;
            $display("FAIL lsh_pass got pass=%b fail=%b exp 1/0", chk_pass, chk_fail);
        end
        tick();
        issue(CMD_LSH, 32'h00000001, 32'h00000021);
        respond(RESP_OK, 32'h00000000);
        exp_fail++;
        checks++;
        if (chk_fail !== 1'b1 || fail_code !== FAIL_DATA) begin
            failures++;
            $display("FAIL lsh_data got fail=%b code=%0d exp 1/1", chk_fail, fail_code);
        end
        tick();
        issue(CMD_RSH, 32'h80000000, 32'hFFFFFFFF);
        respond(RESP_OK, 32'h00000001);
        exp_pass++;
        checks++;
        if (chk_pass !== 1'b1 || chk_fail !== 1'b0) begin
            failures++;
            $display("FAIL rsh_pass got pass=%b fail=%b exp 1/0", chk_pass, chk_fail);
        end
        tick();
    endtask

    task automatic test_sub_invalid();
        issue(CMD_SUB, 32'h00000005, 32'h00000003);
        respond(RESP_OK, 32'h00000002);
        exp_pass++;
        checks++;
        if (chk_pass !== 1'b1) begin
            failures++;
            $display("FAIL sub_pass got pass=%b code=%0d exp 1", chk_pass, fail_code);
        end
        tick();
        // Underflow: only the response code matters, data is ignored.
        issue(CMD_SUB, 32'h00000001, 32'h00000002);
        respond(RESP_ERR, 32'h12345678);
        exp_pass++;
        checks++;
        if (chk_pass !== 1'b1) begin
            failures++;
            $display("FAIL sub_under got pass=%b code=%0d exp 1", chk_pass, fail_code);
        end
        tick();
        issue(4'd3, 32'h00000001, 32'h00000001);
        respond(RESP_OK, 32'h00000002);
        exp_fail++;
        checks++;
        if (chk_fail !== 1'b1 || fail_code !== FAIL_RESP) begin
            failures++;
            $display("FAIL invalid_cmd got fail=%b code=%0d exp 1/2", chk_fail, fail_code);
        end
        tick();
        checks++;
        if (pass_count !== 16'(exp_pass) || fail_count !== 16'(exp_fail)) begin
            failures++;
            $display("FAIL counters got pc=%0d fc=%0d exp %0d/%0d", pass_count, fail_count, exp_pass, exp_fail);
        end
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        issue(CMD_SUB, 32'h00000001, 32'h00000002);
        for (int i = 0; i < 31; i++) begin
            tick();
            if (chk_fail === 1'b1) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL timeout_early got %0d early pulses exp 0", early);
        end
        tick();
        exp_fail++;
        checks++;
        if (chk_fail !== 1'b1 || fail_code !== FAIL_TIMEOUT || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout got fail=%b code=%0d busy=%b exp 1/3/0", chk_fail, fail_code, busy);
        end
        tick();
        checks++;
        if (chk_fail !== 1'b0 || fail_code !== 3'd0) begin
            failures++;
            $display("FAIL timeout_one_pulse got fail=%b code=%0d exp 0/0", chk_fail, fail_code);
        end
    endtask

    task automatic test_overlap();
        issue(CMD_ADD, 32'h00000002, 32'h00000003);
        bus.req_cmd_in  = CMD_ADD;
        bus.req_data_in = 32'h00000007;
        tick();
        bus.req_cmd_in  = '0;
        bus.req_data_in = '0;
        exp_fail++;
        checks++;
        if (chk_fail !== 1'b1 || fail_code !== FAIL_OVERLAP || busy !== 1'b1) begin
            failures++;
            $display("FAIL overlap got fail=%b code=%0d busy=%b exp 1/5/1", chk_fail, fail_code, busy);
        end
        respond(RESP_OK, 32'h00000005);
        exp_pass++;
        checks++;
        if (chk_pass !== 1'b1 || chk_fail !== 1'b0) begin
            failures++;
            $display("FAIL overlap_pass got pass=%b fail=%b exp 1/0", chk_pass, chk_fail);
        end
        tick();
    endtask

    task automatic test_spurious();
        respond(RESP_OK, 32'h00000000);
        exp_fail++;
        checks++;
        if (chk_fail !== 1'b1 || fail_code !== FAIL_SPURIOUS || dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL spurious got fail=%b code=%0d st=%0d exp 1/4/0", chk_fail, fail_code, dbg_state);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        issue(CMD_ADD, 32'h00000001, 32'h00000002);
        respond(RESP_OK, 32'h00000003);
        exp_pass++;
        checks++;
        if (chk_pass !== 1'b1 || dbg_state !== ST_REPORT) begin
            failures++;
            $display("FAIL b2b_first got pass=%b st=%0d exp 1/3", chk_pass, dbg_state);
        end
        issue(CMD_SUB, 32'h00000009, 32'h00000004);
        respond(RESP_OK, 32'h00000005);
        exp_pass++;
        checks++;
        if (chk_pass !== 1'b1 || chk_fail !== 1'b0 || pass_count !== 16'(exp_pass)) begin
            failures++;
            $display("FAIL b2b_second got pass=%b fail=%b pc=%0d exp 1/0/%0d", chk_pass, chk_fail, pass_count, exp_pass);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        issue(CMD_ADD, 32'h00000001, 32'h00000001);
        reset_n = 1'b0;
        #2;
        exp_pass = 0;
        exp_fail = 0;
        checks++;
        if (chk_pass !== 1'b0 || chk_fail !== 1'b0 || busy !== 1'b0 || pass_count !== 16'd0 || fail_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid_clear got pass=%b fail=%b busy=%b pc=%0d fc=%0d exp all 0", chk_pass, chk_fail, busy, pass_count, fail_count);
        end
        reset_n = 1'b1;
        tick();
        respond(RESP_OK, 32'h00000002);
        exp_fail++;
        checks++;
        if (chk_pass !== 1'b0 || chk_fail !== 1'b1 || fail_code !== FAIL_SPURIOUS) begin
            failures++;
            $display("FAIL reset_mid_spur got pass=%b fail=%b code=%0d exp 0/1/4", chk_pass, chk_fail, fail_code);
        end
        checks++;
        if (pass_count !== 16'(exp_pass) || fail_count !== 16'(exp_fail)) begin
            failures++;
            $display("FAIL reset_mid_cnt got pc=%0d fc=%0d exp %0d/%0d", pass_count, fail_count, exp_pass, exp_fail);
        end
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_pass = 0;
        exp_fail = 0;
        test_reset();
        test_add_pass();
        test_add_overflow();
        test_shift();
        test_sub_invalid();
        test_timeout();
        test_overlap();
        test_spurious();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Scoreboard-independent safety net against a stuck run.
    initial begin
        #100000;
        $display("FAIL watchdog run exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/calc1_resp_checker.md
CALC1_RESP_CHECKER -- requirements
Module: calc1_resp_checker

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 32, max cycles from second operand to response before a timeout is declared.
REQ-002 Parameter: PORT_ID, 1, port number (1..4) reported in pass/fail events.
REQ-003 c_clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_cmd_in  input  [0:3]  command being driven into the calc1 port (0=nop, 1=add, 2=sub, 5=lsh, 6=rsh).
REQ-006 req_data_in  input  [0:31]  operand bus driven into the calc1 port.
REQ-007 out_resp_in  input  [0:1]  calc1 port response (0=none, 1=success, 2=overflow/underflow/invalid, 3=internal error).
REQ-008 out_data_in  input  [0:31]  calc1 port result data.
REQ-009 chk_pass  output  1  one-cycle pulse on a correct response.
REQ-010 chk_fail  output  1  one-cycle pulse on any detected error.
REQ-011 fail_code  output  [2:0]  error cause, valid while chk_fail=1, else 0.
REQ-012 pass_count, fail_count  output  [15:0] each  saturating event counters.
REQ-013 busy  output  1  high while a transaction is outstanding (states OP2, WAIT).

Function
REQ-014 FSM states SHALL be IDLE, OP2, WAIT, REPORT.
REQ-015 IDLE: req_cmd_in!=0 captures cmd and req_data_in as op1 -> OP2.
REQ-016 OP2: captures req_data_in as op2 unconditionally -> WAIT; cycle counter cleared.
REQ-017 Expected result SHALL be: add op1+op2, resp 2 on carry out of bit 0; sub op1-op2, resp 2 when op2>op1; lsh op1<<op2[27:31]; rsh op1>>op2[27:31] (zero fill); any other nonzero cmd resp 2; data compared only when expected resp=1.
REQ-018 WAIT: first cycle with out_resp_in!=0 -> REPORT; response may arrive no earlier than the cycle after OP2.
REQ-019 REPORT (one cycle): match -> chk_pass=1; resp mismatch -> fail_code 2; resp ok but data mismatch -> fail_code 1; return to IDLE; a command present in REPORT cycle is accepted as in IDLE.
REQ-020 Timeout: counter reaches TIMEOUT_CYCLES in WAIT with no response -> chk_fail, fail_code 3, -> IDLE.
REQ-021 out_resp_in!=0 in IDLE or OP2 -> chk_fail, fail_code 4 (spurious); FSM state unaffected.
REQ-022 req_cmd_in!=0 in WAIT -> chk_fail, fail_code 5 (overlap); new command ignored, outstanding check continues.
REQ-023 Simultaneous fail events in one cycle: lowest-numbered fail_code reported; only one pulse.
REQ-024 Counters increment once per chk_pass/chk_fail pulse and hold at 16'hFFFF.
REQ-025 chk_pass and chk_fail SHALL never be high together; both registered outputs.

Reset
REQ-026 reset_n low SHALL asynchronously force state IDLE, all outputs 0, counters 0, captured cmd/op1/op2 0.
REQ-027 Reset mid-transaction SHALL discard the outstanding check without any pass/fail pulse.
REQ-028 First command is accepted on the first rising edge after reset_n deasserts.

Structure
REQ-029 Package calc1_pkg SHALL hold command codes, response codes, fail codes (1 data, 2 resp, 3 timeout, 4 spurious, 5 overlap) and the FSM state type.
REQ-030 Expected-result computation SHALL be a combinational sub-module calc1_ref_model (cmd, op1, op2 -> exp_resp, exp_data).
REQ-031 One instance per calc1 port; no shared state between instances.

Verification
REQ-032 add 0xFFFF0000, 0x0000FFFF; DUT resp 1 data 0xFFFFFFFF after 3 cycles -> chk_pass, pass_count=1.
REQ-033 add 0xFFFFFFFF, 0x00000001; DUT resp 1 data 0x00000000 -> chk_fail, fail_code 2.
REQ-034 lsh 0x00000001, 0x00000021; DUT resp 1 data 0x00000002 -> chk_pass; DUT data 0x00000000 -> fail_code 1.
REQ-035 sub 0x00000001, 0x00000002, no response for 32 cycles -> chk_fail, fail_code 3 in cycle 32, busy drops.
REQ-036 add issued, second add issued during WAIT, then correct response -> fail_code 5 pulse, then chk_pass.
REQ-037 reset_n pulsed low in WAIT then response arrives -> no pass, fail_code 4 spurious, counters reflect only post-reset events.
